// File: rtl/ysyx_22041207_axi_pkg.sv
// Shared constants for the read-channel arbiter: FSM encoding and arbitration modes.
package ysyx_22041207_axi_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

endpackage

// File: rtl/ysyx_22041207_rr_picker.sv
// Winner selection: round-robin starting after last_grant, or fixed priority (index 0 first).
module ysyx_22041207_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             mode,
  output logic [N-1:0]     grant
);

  logic [IDX_W-1:0] pos;
  logic             found;

  always_comb begin
    grant = '0;
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = mode ? IDX_W'((int'(last_grant) + 1 + k) % N) : IDX_W'(k);
      if (!found && req[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22041207_axi_arbiter.sv
// Read-request arbiter: N_MST masters share one downstream read port (IF/MEM map to N_MST=2, MEM on 0).
// state | meaning
// IDLE  | no owner; pick a winner when any request is valid
// ADDR  | forward owner's address/size downstream until accepted
// DATA  | route downstream read data to owner until handshake completes
module ysyx_22041207_axi_arbiter #(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MODE   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_MST-1:0]        m_r_valid_i,
  output logic [N_MST-1:0]        m_r_ready_o,
  input  logic [N_MST*ADDR_W-1:0] m_r_addr_i,
  input  logic [N_MST*8-1:0]      m_r_size_i,
  output logic [DATA_W-1:0]       m_data_o,
  output logic [N_MST-1:0]        m_data_valid_o,
  input  logic [N_MST-1:0]        m_data_ready_i,
  output logic                    dn_r_valid_o,
  input  logic                    dn_r_ready_i,
  output logic [ADDR_W-1:0]       dn_r_addr_o,
  output logic [7:0]              dn_r_size_o,
  input  logic [DATA_W-1:0]       dn_data_i,
  input  logic                    dn_data_valid_i,
  output logic                    dn_data_ready_o,
  output logic [N_MST-1:0]        grant_o
);
  import ysyx_22041207_axi_pkg::*;

  localparam int IDX_W = (N_MST > 1) ? $clog2(N_MST) : 1;

  logic [1:0]        state;
  logic [IDX_W-1:0]  gidx;
  logic [IDX_W-1:0]  last_grant;
  logic [N_MST-1:0]  pick;
  logic [IDX_W-1:0]  pick_idx;
  logic [ADDR_W-1:0] addr_arr [N_MST];
  logic [7:0]        size_arr [N_MST];

  for (genvar k = 0; k < N_MST; k++) begin : g_unpack
    assign addr_arr[k] = m_r_addr_i[k*ADDR_W +: ADDR_W];
    assign size_arr[k] = m_r_size_i[k*8 +: 8];
  end

  ysyx_22041207_rr_picker #(
    .N     (N_MST),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (m_r_valid_i),
    .last_grant (last_grant),
    .mode       (MODE == MODE_RR),
    .grant      (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < N_MST; k++) begin
      if (pick[k]) pick_idx = IDX_W'(k);
    end
  end

  // last_grant moves only on a completed data phase, so abandoned transfers don't rotate priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      grant_o    <= '0;
      gidx       <= '0;
      last_grant <= IDX_W'(N_MST - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_r_valid_i) begin
            state   <= ST_ADDR;
            grant_o <= pick;
            gidx    <= pick_idx;
          end
        end
        ST_ADDR: begin
          if (dn_r_ready_i) state <= ST_DATA;
        end
        ST_DATA: begin
          if (dn_data_valid_i && m_data_ready_i[gidx]) begin
            state      <= ST_IDLE;
            grant_o    <= '0;
            last_grant <= gidx;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_r_ready_o     = '0;
    m_data_valid_o  = '0;
    m_data_o        = '0;
    dn_r_valid_o    = 1'b0;
    dn_r_addr_o     = '0;
    dn_r_size_o     = '0;
    dn_data_ready_o = 1'b0;
    case (state)
      ST_ADDR: begin
        dn_r_valid_o      = 1'b1;
        dn_r_addr_o       = addr_arr[gidx];
        dn_r_size_o       = size_arr[gidx];
        m_r_ready_o[gidx] = dn_r_ready_i;
      end
      ST_DATA: begin
        m_data_o             = dn_data_i;
        m_data_valid_o[gidx] = dn_data_valid_i;
        dn_data_ready_o      = m_data_ready_i[gidx];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22041207_axi_arbiter.sv
// Scoreboard bench: a round-robin instance (N_MST=4) and a fixed-priority instance (N_MST=4).
module tb_ysyx_22041207_axi_arbiter;

  typedef struct {
    int          g;
    logic [63:0] d;
  } dexp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   m_r_valid_i = '0;
  logic [3:0]   m_r_ready_o;
  logic [255:0] m_r_addr_i;
  logic [31:0]  m_r_size_i;
  logic [63:0]  m_data_o;
  logic [3:0]   m_data_valid_o;
  logic [3:0]   m_data_ready_i = '0;
  logic         dn_r_valid_o;
  logic         dn_r_ready_i = 1'b0;
  logic [63:0]  dn_r_addr_o;
  logic [7:0]   dn_r_size_o;
  logic [63:0]  dn_data_i = '0;
  logic         dn_data_valid_i = 1'b0;
  logic         dn_data_ready_o;
  logic [3:0]   grant_o;

  logic [3:0]   fp_valid = '0;
  logic [3:0]   fp_r_ready;
  logic [63:0]  fp_data;
  logic [3:0]   fp_data_valid;
  logic [3:0]   fp_m_data_ready = '0;
  logic         fp_dn_r_valid;
  logic         fp_dn_r_ready = 1'b0;
  logic [63:0]  fp_dn_addr;
  logic [7:0]   fp_dn_size;
  logic [63:0]  fp_dn_data = '0;
  logic         fp_dn_data_valid = 1'b0;
  logic         fp_dn_data_ready;
  logic [3:0]   fp_grant;

  ysyx_22041207_axi_arbiter #(.N_MST(4), .ADDR_W(64), .DATA_W(64), .MODE(1)) u_rr (
    .clk(clk), .rst(rst),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
    .m_r_addr_i(m_r_addr_i), .m_r_size_i(m_r_size_i),
    .m_data_o(m_data_o), .m_data_valid_o(m_data_valid_o), .m_data_ready_i(m_data_ready_i),
    .dn_r_valid_o(dn_r_valid_o), .dn_r_ready_i(dn_r_ready_i),
    .dn_r_addr_o(dn_r_addr_o), .dn_r_size_o(dn_r_size_o),
    .dn_data_i(dn_data_i), .dn_data_valid_i(dn_data_valid_i), .dn_data_ready_o(dn_data_ready_o),
    .grant_o(grant_o)
  );

  ysyx_22041207_axi_arbiter #(.N_MST(4), .ADDR_W(64), .DATA_W(64), .MODE(0)) u_fp (
    .clk(clk), .rst(rst),
    .m_r_valid_i(fp_valid), .m_r_ready_o(fp_r_ready),
    .m_r_addr_i(m_r_addr_i), .m_r_size_i(m_r_size_i),
    .m_data_o(fp_data), .m_data_valid_o(fp_data_valid), .m_data_ready_i(fp_m_data_ready),
    .dn_r_valid_o(fp_dn_r_valid), .dn_r_ready_i(fp_dn_r_ready),
    .dn_r_addr_o(fp_dn_addr), .dn_r_size_o(fp_dn_size),
    .dn_data_i(fp_dn_data), .dn_data_valid_i(fp_dn_data_valid), .dn_data_ready_o(fp_dn_data_ready),
    .grant_o(fp_grant)
  );

  int    n_pass  = 0;
  int    n_total = 0;
  int    acc_cnt = 0;
  int    exp_req_q[$];
  dexp_t exp_dat_q[$];
  int    fp_q[$];

  function automatic logic [63:0] exp_addr(input int g);
    return 64'h8000_0000 + 64'(g) * 64'h100;
  endfunction

  function automatic logic [3:0] onehot(input int g);
    return 4'b0001 << g;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // Monitors: pop the scoreboard whenever a handshake is presented
  initial begin
    forever begin
      @(negedge clk);
      if (dn_r_valid_o) chk("req_held_in_addr", 64'(|(m_r_valid_i & grant_o)), 64'd1);
      if (|m_r_ready_o) begin
        acc_cnt++;
        if (exp_req_q.size() == 0) chk("unexpected_accept", 64'(m_r_ready_o), 64'd0);
        else begin
          automatic int g = exp_req_q.pop_front();
          chk("req_grant", 64'(m_r_ready_o), 64'(onehot(g)));
          chk("grant_o", 64'(grant_o), 64'(onehot(g)));
          chk("req_addr", dn_r_addr_o, exp_addr(g));
          chk("req_size", 64'(dn_r_size_o), 64'(g + 3));
        end
      end
      if (|(m_data_valid_o & m_data_ready_i)) begin
        if (exp_dat_q.size() == 0) chk("unexpected_data", 64'(m_data_valid_o), 64'd0);
        else begin
          automatic dexp_t e = exp_dat_q.pop_front();
          chk("data_owner", 64'(m_data_valid_o), 64'(onehot(e.g)));
          chk("data_value", m_data_o, e.d);
          chk("data_ready_fwd", 64'(dn_data_ready_o), 64'd1);
        end
      end
      if (|fp_r_ready) begin
        if (fp_q.size() == 0) chk("fp_unexpected_accept", 64'(fp_r_ready), 64'd0);
        else begin
          automatic int g = fp_q.pop_front();
          chk("fp_grant", 64'(fp_r_ready), 64'(onehot(g)));
          chk("fp_never_3", 64'(fp_grant[3]), 64'd0);
        end
      end
    end
  end

  task automatic do_txn(input logic [3:0] req, input int g, input int rdy_delay,
                        input int dready_delay, input logic [63:0] data);
    int acc0;
    exp_req_q.push_back(g);
    exp_dat_q.push_back('{g, data});
    m_r_valid_i = req;
    for (int n = 0; n < 10 && !dn_r_valid_o; n++) begin
      @(posedge clk); #1;
    end
    chk("addr_wait", 64'(dn_r_valid_o), 64'd1);
    if (!dn_r_valid_o) return;
    acc0 = acc_cnt;
    for (int i = 0; i < rdy_delay; i++) begin
      @(negedge clk);
      chk("addr_hold_valid", 64'(dn_r_valid_o), 64'd1);
      chk("addr_hold_addr", dn_r_addr_o, exp_addr(g));
      chk("addr_hold_no_ready", 64'(m_r_ready_o), 64'd0);
      @(posedge clk); #1;
    end
    dn_r_ready_i = 1'b1;
    @(posedge clk); #1;
    dn_r_ready_i    = 1'b0;
    dn_data_i       = data;
    dn_data_valid_i = 1'b1;
    m_data_ready_i  = '0;
    for (int i = 0; i < dready_delay; i++) begin
      @(negedge clk);
      chk("data_hold_value", m_data_o, data);
      chk("data_hold_valid", 64'(m_data_valid_o), 64'(onehot(g)));
      chk("data_hold_dn_ready", 64'(dn_data_ready_o), 64'd0);
      chk("data_hold_grant", 64'(grant_o), 64'(onehot(g)));
      @(posedge clk); #1;
    end
    m_data_ready_i = '1;
    @(posedge clk); #1;
    dn_data_valid_i = 1'b0;
    dn_data_i       = '0;
    m_data_ready_i  = '0;
    @(negedge clk);
    chk("idle_grant_clear", 64'(grant_o), 64'd0);
    chk("idle_no_dn_valid", 64'(dn_r_valid_o), 64'd0);
    chk("ready_pulse_once", 64'(acc_cnt - acc0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    automatic int acc;
    for (int k = 0; k < 4; k++) begin
      m_r_addr_i[k*64 +: 64] = exp_addr(k);
      m_r_size_i[k*8 +: 8]   = 8'(k + 3);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_dn_valid", 64'(dn_r_valid_o), 64'd0);
    chk("rst_r_ready", 64'(m_r_ready_o), 64'd0);
    chk("rst_data_valid", 64'(m_data_valid_o), 64'd0);
    chk("rst_dn_data_ready", 64'(dn_data_ready_o), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // both low masters request continuously: 0,1,0,1
    do_txn(4'b0011, 0, 5, 0, 64'h1111_0000);
    do_txn(4'b0011, 1, 0, 0, 64'h2222_0001);
    do_txn(4'b0011, 0, 0, 3, 64'hDEAD_BEEF);
    do_txn(4'b0011, 1, 1, 1, 64'h4444_0003);
    // wrap behaviour
    do_txn(4'b1000, 3, 0, 0, 64'h5555_0004);
    do_txn(4'b0001, 0, 0, 0, 64'h6666_0005);
    do_txn(4'b1001, 3, 2, 0, 64'h7777_0006);
    do_txn(4'b1111, 0, 0, 0, 64'h8888_0007);
    do_txn(4'b1111, 1, 0, 0, 64'h9999_0008);
    m_r_valid_i = '0;

    // request withdrawn in IDLE before the edge must not be granted
    @(posedge clk); #1;
    m_r_valid_i = 4'b0100;
    @(negedge clk);
    m_r_valid_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drop_no_grant", 64'(grant_o), 64'd0);
    chk("drop_no_dn_valid", 64'(dn_r_valid_o), 64'd0);

    // reset during DATA abandons the transfer and restores master 0 priority
    @(posedge clk); #1;
    exp_req_q.push_back(1);
    m_r_valid_i = 4'b0010;
    for (int n = 0; n < 10 && !dn_r_valid_o; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_seq_addr_wait", 64'(dn_r_valid_o), 64'd1);
    dn_r_ready_i = 1'b1;
    @(posedge clk); #1;
    dn_r_ready_i    = 1'b0;
    dn_data_i       = 64'h1234_5678;
    dn_data_valid_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_data_valid", 64'(m_data_valid_o), 64'b0010);
    #2 rst = 1'b0;
    #1;
    chk("rst_data_valid_same_cycle", 64'(m_data_valid_o), 64'd0);
    chk("rst_grant_same_cycle", 64'(grant_o), 64'd0);
    chk("rst_dn_ready_same_cycle", 64'(dn_data_ready_o), 64'd0);
    dn_data_valid_i = 1'b0;
    dn_data_i       = '0;
    m_r_valid_i     = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b1;
    do_txn(4'b1111, 0, 0, 0, 64'hAAAA_0009);
    m_r_valid_i = '0;

    // fixed-priority instance: 0b1010 always gives master 1
    fp_dn_r_ready    = 1'b1;
    fp_dn_data_valid = 1'b1;
    fp_dn_data       = 64'hF00D;
    fp_m_data_ready  = '1;
    repeat (4) fp_q.push_back(1);
    fp_valid = 4'b1010;
    acc = 0;
    for (int n = 0; n < 60 && acc < 4; n++) begin
      @(negedge clk);
      if (|fp_r_ready) acc++;
    end
    @(posedge clk); #1;
    fp_valid = '0;
    chk("fp_accept_count_1010", 64'(acc), 64'd4);
    repeat (3) @(posedge clk);
    #1;
    repeat (2) fp_q.push_back(2);
    fp_valid = 4'b1100;
    acc = 0;
    for (int n = 0; n < 60 && acc < 2; n++) begin
      @(negedge clk);
      if (|fp_r_ready) acc++;
    end
    @(posedge clk); #1;
    fp_valid = '0;
    chk("fp_accept_count_1100", 64'(acc), 64'd2);
    repeat (4) @(posedge clk);

    chk("req_queue_drained", 64'(exp_req_q.size()), 64'd0);
    chk("data_queue_drained", 64'(exp_dat_q.size()), 64'd0);
    chk("fp_queue_drained", 64'(fp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ysyx_22041207_axi_arbiter.md
YSYX_22041207_AXI_ARBITER -- requirements
Module: ysyx_22041207_axi_arbiter

Interface
REQ-001 SHALL have parameter N_MST, default 2, giving the number of upstream read masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64, giving the address width.
REQ-003 SHALL have parameter DATA_W, default 64, giving the read-data width.
REQ-004 SHALL have parameter MODE, default 1, where 0 selects fixed priority (index 0 highest) and 1 selects round-robin.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 m_r_valid_i  in  N_MST  per-master read request valid.
REQ-008 m_r_ready_o  out  N_MST  per-master request accepted (one-hot or zero).
REQ-009 m_r_addr_i  in  N_MST*ADDR_W  per-master request address, packed with master 0 in the LSBs.
REQ-010 m_r_size_i  in  N_MST*8  per-master transfer size, packed.
REQ-011 m_data_o  out  DATA_W  returned read data, shared by all masters.
REQ-012 m_data_valid_o  out  N_MST  per-master data valid (one-hot or zero).
REQ-013 m_data_ready_i  in  N_MST  per-master data ready.
REQ-014 dn_r_valid_o / dn_r_ready_i  out/in  1  downstream request handshake to axi_rw.
REQ-015 dn_r_addr_o  out  ADDR_W  and dn_r_size_o  out  8  carry the forwarded request.
REQ-016 dn_data_i  in  DATA_W  carries downstream read data.
REQ-017 dn_data_valid_i / dn_data_ready_o  in/out  1  downstream data handshake.
REQ-018 grant_o  out  N_MST  exposes the current owner, one-hot, for debug and bench use.

Function
REQ-019 FSM SHALL have states IDLE, ADDR, and DATA.
REQ-020 In IDLE with any m_r_valid_i set, SHALL latch the winner into grant_o and go to ADDR on the next edge; SHALL NOT assert any output handshake in IDLE.
REQ-021 In ADDR, dn_r_valid_o SHALL be 1 and dn_r_addr_o/dn_r_size_o SHALL mux from the granted master; on dn_r_ready_i=1, m_r_ready_o[g] SHALL pulse for that cycle and the FSM SHALL go to DATA.
REQ-022 In DATA, m_data_o SHALL be dn_data_i, m_data_valid_o[g] SHALL be dn_data_valid_i, and dn_data_ready_o SHALL be m_data_ready_i[g], all combinational; on a completed data handshake the FSM SHALL return to IDLE.
REQ-023 Grant SHALL be held constant from ADDR entry until DATA exit; request changes from other masters SHALL be ignored while held.
REQ-024 MODE=1: the search SHALL start at (last_grant+1) mod N_MST, wrapping at N_MST-1 to 0; last_grant SHALL update only on DATA exit.
REQ-025 MODE=0: the lowest asserted index SHALL win.
REQ-026 Minimum transaction SHALL be 3 cycles (IDLE, ADDR, DATA), and IDLE SHALL be revisited for at least one cycle between transactions.
REQ-027 A request deasserted while in IDLE before the grant edge SHALL NOT be granted; a request deasserted in ADDR is illegal, and its behaviour is undefined, with the bench asserting against it.
REQ-028 All outputs not owned by the granted index SHALL be 0.

Reset
REQ-029 Asserting rst at any time SHALL force IDLE, grant_o=0, and last_grant=N_MST-1 (so master 0 wins first), with all handshake outputs 0; an in-flight transaction SHALL be abandoned without a completion pulse.
REQ-030 Outputs SHALL become valid the first edge after rst deasserts.

Structure
REQ-031 State encoding (IDLE=0, ADDR=1, DATA=2) and the MODE constants SHALL live in package ysyx_22041207_axi_pkg.
REQ-032 Winner selection SHALL be a sub-module ysyx_22041207_rr_picker (inputs: req, last_grant, mode; output: one-hot grant).
REQ-033 Existing IF/MEM connections SHALL map to N_MST=2 with MEM on index 0.

Verification
REQ-034 N_MST=2, MODE=1: both masters request continuously for 4 transactions -> grants go 0,1,0,1.
REQ-035 MODE=0, N_MST=4: requests 0b1010 held -> master 1 is always granted and master 3 is never granted.
REQ-036 N_MST=4, MODE=1, last_grant=3, req=0b0001 -> wrap grants 0; then with req=0b1001 -> grants 3.
REQ-037 With dn_r_ready_i held low 5 cycles -> dn_r_valid_o stays 1 with stable addr 0x80000000, and m_r_ready_o pulses exactly once after ready.
REQ-038 rst asserted during DATA with dn_data_valid_i=1 -> same-cycle m_data_valid_o=0 and grant_o=0, and master 0 wins first after release.
REQ-039 m_data_ready_i[g]=0 for 3 cycles with data 0xDEADBEEF -> data is held, dn_data_ready_o=0, and the FSM stays in DATA until ready.
